raster_scan_gen: RTL and testbench

- Parametrised successor to the fixed 640x480 raster counter.
- Generates x/y beam position, active-video and sync strobes, and line/frame pulses for the VGA output path.
- Adds the following over the fixed counter:
  - timings and sync polarity set by parameters;
  - a clock-enable for pausing or dividing the counters;
  - a programmable line-prefetch pulse so pixel fetch logic can start before active video;
  - a free-running frame counter.

---
 rtl/raster_scan_gen.sv | 152 +++++++++++++++
 tb/tb_raster_scan_gen.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/raster_scan_gen.sv
`default_nettype none
// ============================================================================
// Module   : raster_scan_gen
// Purpose  : Parametrised raster scan generator. Produces the signed x / unsigned
//            y beam position, active-video window, sync strobes, and the
//            line/frame/prefetch pulses that drive the VGA output path.
//            Includes a free-running frame counter.
// Ports    : clk          - clock
//            reset_n      - asynchronous active-low reset
//            enable       - advance the counters this cycle
//            x            - signed horizontal position (back porch is x < 0)
//            y            - line number
//            active       - inside active video
//            hsync/vsync  - sync strobes, levels set by HSYNC_POL/VSYNC_POL
//            new_line     - one-clock pulse on the last clock of a line
//            new_frame    - one-clock pulse on the last clock of a frame
//            prefetch     - one-clock pulse PREFETCH clocks before pixel 0 of
//                           an active line
//            frame_count  - completed frames, wraps
// Revision : 1.0 - initial release
// ============================================================================
module raster_scan_gen #(
    parameter int X_BITS     = 12,
    parameter int Y_BITS     = 10,
    parameter int H_ACTIVE   = 1280,
    parameter int H_FP       = 32,
    parameter int H_SYNC     = 192,
    parameter int H_BP       = 96,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit HSYNC_POL  = 1'b0,
    parameter bit VSYNC_POL  = 1'b0,
    parameter int PREFETCH   = 16,
    parameter int FRAME_BITS = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    output logic signed [X_BITS-1:0] x,
    output logic [Y_BITS-1:0]        y,
    output logic                     active,
    output logic                     hsync,
    output logic                     vsync,
    output logic                     new_line,
    output logic                     new_frame,
    output logic                     prefetch,
    output logic [FRAME_BITS-1:0]    frame_count
);

    // Derived timing, in plain integers for the elaboration checks.
    localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_x0      = -H_BP;
    localparam int c_x_last  = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int c_hs0     = H_ACTIVE + H_FP;
    localparam int c_vs0     = V_ACTIVE + V_FP;
    localparam longint c_x_min = -(longint'(1) <<< (X_BITS - 1));
    localparam longint c_x_max = (longint'(1) <<< (X_BITS - 1)) - 1;
    localparam longint c_y_max = (longint'(1) <<< Y_BITS) - 1;

    // The same constants sized to the counters so every compare is same-width.
    localparam logic signed [X_BITS-1:0] c_x0_s       = X_BITS'(c_x0);
    localparam logic signed [X_BITS-1:0] c_x_last_s   = X_BITS'(c_x_last);
    localparam logic signed [X_BITS-1:0] c_h_active_s = X_BITS'(H_ACTIVE);
    localparam logic signed [X_BITS-1:0] c_hs0_s      = X_BITS'(c_hs0);
    localparam logic signed [X_BITS-1:0] c_pref_s     = X_BITS'(-PREFETCH);
    localparam logic [Y_BITS-1:0]        c_y_last     = Y_BITS'(c_v_total - 1);
    localparam logic [Y_BITS-1:0]        c_v_active_y = Y_BITS'(V_ACTIVE);
    localparam logic [Y_BITS-1:0]        c_vs0_y      = Y_BITS'(c_vs0);
    localparam logic [Y_BITS-1:0]        c_vs_last_y  = Y_BITS'(c_vs0 + V_SYNC - 1);

    // ------------------------------------------------------------------------
    // Elaboration-time legality checks
    // ------------------------------------------------------------------------
    if (PREFETCH < 1 || PREFETCH > H_BP) begin : g_bad_prefetch
        $error("raster_scan_gen: PREFETCH=%0d outside 1..H_BP=%0d", PREFETCH, H_BP);
    end
    if (longint'(c_x0) < c_x_min || longint'(c_x_last) > c_x_max) begin : g_bad_x_bits
        $error("raster_scan_gen: x range %0d..%0d does not fit signed X_BITS=%0d",
               c_x0, c_x_last, X_BITS);
    end
    if (longint'(c_v_total - 1) > c_y_max) begin : g_bad_y_bits
        $error("raster_scan_gen: V_TOTAL-1=%0d does not fit Y_BITS=%0d",
               c_v_total - 1, Y_BITS);
    end

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic signed [X_BITS-1:0] r_x;
    logic [Y_BITS-1:0]        r_y;
    logic [FRAME_BITS-1:0]    r_frame_count;

    logic w_x_last;
    logic w_y_last;
    logic w_new_line;
    logic w_new_frame;

    assign w_x_last = (r_x == c_x_last_s);
    assign w_y_last = (r_y == c_y_last);

    // Pulses are additionally gated by reset_n: when PREFETCH equals H_BP the
    // reset position x = X0 coincides with the prefetch point, and the pulse
    // must stay quiet while reset is held.
    assign w_new_line  = reset_n && enable && w_x_last;
    assign w_new_frame = w_new_line && w_y_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x           <= c_x0_s;
            r_y           <= '0;
            r_frame_count <= '0;
        end else if (enable) begin
            if (w_x_last) begin
                r_x <= c_x0_s;
                r_y <= w_y_last ? '0 : r_y + Y_BITS'(1);
            end else begin
                r_x <= r_x + X_BITS'(1);
            end
            if (w_new_frame) begin
                r_frame_count <= r_frame_count + FRAME_BITS'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Decoded outputs, zero latency relative to x/y
    // ------------------------------------------------------------------------
    logic w_active;
    logic w_hs_window;
    logic w_vs_window;

    // The sign bit alone tells us x < 0.
    assign w_active    = !r_x[X_BITS-1] && (r_x < c_h_active_s) && (r_y < c_v_active_y);
    // Sync is the last horizontal segment, so its upper bound is X_LAST itself
    // and needs no compare (avoids forming X_LAST+1, which may not fit).
    assign w_hs_window = (r_x >= c_hs0_s);
    assign w_vs_window = (r_y >= c_vs0_y) && (r_y <= c_vs_last_y);

    assign x           = r_x;
    assign y           = r_y;
    assign active      = w_active;
    assign hsync       = w_hs_window ? HSYNC_POL : !HSYNC_POL;
    assign vsync       = w_vs_window ? VSYNC_POL : !VSYNC_POL;
    assign new_line    = w_new_line;
    assign new_frame   = w_new_frame;
    assign prefetch    = reset_n && enable && (r_x == c_pref_s) && (r_y < c_v_active_y);
    assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_raster_scan_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_raster_scan_gen
// Purpose  : Self-checking bench for raster_scan_gen. Two instances run side
//            by side: one with default 1280-wide timing, one with a tiny
//            10x5 raster and a 2-bit frame counter so full frames, vsync and
//            frame-count wrap are reachable in a short run. Expected outputs
//            are pushed to a queue by the stimulus and checked at the falling
//            edge by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_raster_scan_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n = 1'b0;
    logic en_d    = 1'b0;
    logic en_s    = 1'b0;

    // Default-timing instance
    logic signed [11:0] x_d;
    logic [9:0]         y_d;
    logic               act_d, hs_d, vs_d, nl_d, nf_d, pf_d;
    logic [7:0]         fc_d;

    raster_scan_gen u_dut_dflt (
        .clk(clk), .reset_n(reset_n), .enable(en_d),
        .x(x_d), .y(y_d), .active(act_d), .hsync(hs_d), .vsync(vs_d),
        .new_line(nl_d), .new_frame(nf_d), .prefetch(pf_d), .frame_count(fc_d)
    );

    // Small-raster instance
    logic signed [11:0] x_s;
    logic [9:0]         y_s;
    logic               act_s, hs_s, vs_s, nl_s, nf_s, pf_s;
    logic [1:0]         fc_s;

    raster_scan_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(3),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PREFETCH(3), .FRAME_BITS(2)
    ) u_dut_small (
        .clk(clk), .reset_n(reset_n), .enable(en_s),
        .x(x_s), .y(y_s), .active(act_s), .hsync(hs_s), .vsync(vs_s),
        .new_line(nl_s), .new_frame(nf_s), .prefetch(pf_s), .frame_count(fc_s)
    );

    typedef struct {
        bit sel;   // 0 = default instance, 1 = small instance
        int x;
        int y;
        bit act, hs, vs, nl, nf, pf;
        int fc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   nd = 0;   // enabled clocks since reset, default instance
    int   ns = 0;   // enabled clocks since reset, small instance

    // Default timing: 1600 clocks/line, 525 lines, hsync low x=1312..1503,
    // vsync low y=490..491, prefetch at x=-16 on lines 0..479.
    function automatic exp_t exp_dflt(input int n, input bit en, input bit in_rst);
        exp_t e;
        e.sel = 1'b0;
        e.x   = (n % 1600) - 96;
        e.y   = (n / 1600) % 525;
        e.fc  = (n / 840000) % 256;
        e.act = (e.x >= 0) && (e.x < 1280) && (e.y < 480);
        e.hs  = !((e.x >= 1312) && (e.x <= 1503));
        e.vs  = !((e.y == 490) || (e.y == 491));
        e.nl  = !in_rst && en && (e.x == 1503);
        e.nf  = e.nl && (e.y == 524);
        e.pf  = !in_rst && en && (e.x == -16) && (e.y < 480);
        return e;
    endfunction

    // Small timing: x -3..6 (10 clocks), y 0..4, 50 clocks/frame,
    // hsync high x=5,6, vsync high y=3, prefetch at x=-3 on y=0,1.
    function automatic exp_t exp_small(input int n, input bit en, input bit in_rst);
        exp_t e;
        e.sel = 1'b1;
        e.x   = (n % 10) - 3;
        e.y   = (n / 10) % 5;
        e.fc  = (n / 50) % 4;
        e.act = (e.x >= 0) && (e.x < 4) && (e.y < 2);
        e.hs  = (e.x == 5) || (e.x == 6);
        e.vs  = (e.y == 3);
        e.nl  = !in_rst && en && (e.x == 6);
        e.nf  = e.nl && (e.y == 4);
        e.pf  = !in_rst && en && (e.x == -3) && (e.y < 2);
        return e;
    endfunction

    // One clock of stimulus. Counts the edge just taken, applies new inputs,
    // optionally releases reset or asserts it between edges, and queues the
    // outputs expected at the following falling edge.
    task automatic cyc(input bit ed, input bit es, input bit rel, input bit rst_mid);
        @(posedge clk);
        #1;
        if (reset_n) begin
            if (en_d) nd++;
            if (en_s) ns++;
        end
        en_d = ed;
        en_s = es;
        if (rel) reset_n = 1'b1;
        if (rst_mid) begin
            #1;
            reset_n = 1'b0;
            nd = 0;
            ns = 0;
        end
        q.push_back(exp_dflt(nd, en_d, !reset_n));
        q.push_back(exp_small(ns, en_s, !reset_n));
    endtask

    // Direct check of the reset values on both instances.
    task automatic check_reset_state(input string tag);
        #1;
        n_cmp++;
        if (x_d !== -12'sd96 || y_d !== 10'd0 || act_d !== 1'b0 ||
            hs_d !== 1'b1 || vs_d !== 1'b1 || nl_d !== 1'b0 ||
            nf_d !== 1'b0 || pf_d !== 1'b0 || fc_d !== 8'd0 ||
            x_s !== -12'sd3 || y_s !== 10'd0 || act_s !== 1'b0 ||
            hs_s !== 1'b0 || vs_s !== 1'b0 || nl_s !== 1'b0 ||
            nf_s !== 1'b0 || pf_s !== 1'b0 || fc_s !== 2'd0) begin
            n_bad++;
            $display("FAIL reset-state (%s) @%0t: dflt x=%0d y=%0d act=%0b hs=%0b vs=%0b fc=%0d, small x=%0d y=%0d act=%0b hs=%0b vs=%0b fc=%0d",
                     tag, $time, x_d, y_d, act_d, hs_d, vs_d, fc_d,
                     x_s, y_s, act_s, hs_s, vs_s, fc_s);
        end
    endtask

    // Monitor: compare every queued expectation against the live outputs.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            exp_t a;
            e = q.pop_front();
            a.sel = e.sel;
            if (e.sel == 1'b0) begin
                a.x = int'(x_d); a.y = int'(y_d); a.fc = int'(fc_d);
                a.act = act_d; a.hs = hs_d; a.vs = vs_d;
                a.nl = nl_d; a.nf = nf_d; a.pf = pf_d;
            end else begin
                a.x = int'(x_s); a.y = int'(y_s); a.fc = int'(fc_s);
                a.act = act_s; a.hs = hs_s; a.vs = vs_s;
                a.nl = nl_s; a.nf = nf_s; a.pf = pf_s;
            end
            n_cmp++;
            if (a.x != e.x || a.y != e.y || a.fc != e.fc || a.act != e.act ||
                a.hs != e.hs || a.vs != e.vs || a.nl != e.nl || a.nf != e.nf ||
                a.pf != e.pf) begin
                n_bad++;
                $display("FAIL %s @%0t: got x=%0d y=%0d act=%0b hs=%0b vs=%0b nl=%0b nf=%0b pf=%0b fc=%0d, expected x=%0d y=%0d act=%0b hs=%0b vs=%0b nl=%0b nf=%0b pf=%0b fc=%0d",
                         e.sel ? "small" : "dflt", $time,
                         a.x, a.y, a.act, a.hs, a.vs, a.nl, a.nf, a.pf, a.fc,
                         e.x, e.y, e.act, e.hs, e.vs, e.nl, e.nf, e.pf, e.fc);
            end
        end
    end

    initial begin
        // Reset held with enable high: reset values, no pulses.
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check_reset_state("initial");

        // Release and free-run: covers first lines of the default raster and
        // many complete small frames (frame_count wraps 3 -> 0).
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 3300; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0);

        // Half-rate enable: one full 3200-clock line and beyond.
        for (int k = 0; k < 3400; k++) cyc(k % 2 == 0, k % 2 == 0, 1'b0, 1'b0);

        // Irregular stalls on the small raster while the default one holds.
        for (int k = 0; k < 300; k++) cyc(1'b0, (k % 3) != 0, 1'b0, 1'b0);

        // Run the default raster into active video, then assert reset
        // between clock edges around x = 700.
        for (int k = 0; k < 4000 && (nd % 1600) != 795; k++)
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
        if ((nd % 1600) != 795) begin
            n_bad++;
            $display("FAIL timeout @%0t: default raster never reached x=699 (nd=%0d)",
                     $time, nd);
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        check_reset_state("mid-line async");
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0);

        // Release and confirm counting resumes from X0.
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 200; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        if (n_cmp == 0 || n_bad != 0)
            $display("FAIL: %0d compared / %0d mismatched", n_cmp, n_bad);
        else
            $display("PASS");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
